// File: rtl/channel_combiner.sv
// channel_combiner
//   Pops one word from each of two show-ahead FIFOs (A and B) in lockstep,
//   combines them (A-B, A+B, (A+B)/2, B-A), dequantizes with an arithmetic
//   right shift rounded toward zero, optionally saturates, and presents the
//   result through a one-entry output register to an output FIFO.
//
// Parameters
//   DATA_WIDTH : sample width of A, B and the output word (two's complement)
//   SHIFT      : dequantize right shift, 0..DATA_WIDTH-1
//   SATURATE   : 1 = clamp to the signed DATA_WIDTH range, 0 = keep low bits
//   CNT_WIDTH  : width of sample_count
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   a_dout       in   head word of FIFO A
//   a_empty      in   FIFO A empty
//   a_rd_en      out  pop FIFO A
//   b_dout       in   head word of FIFO B
//   b_empty      in   FIFO B empty
//   b_rd_en      out  pop FIFO B
//   op_sel       in   00 A-B, 01 A+B, 10 (A+B)/2, 11 B-A
//   out_din      out  result word to the output FIFO (0 while nothing held)
//   out_full     in   output FIFO full
//   out_wr_en    out  push to the output FIFO
//   sample_count out  words written since reset (wraps)
module channel_combiner #(
    parameter int DATA_WIDTH = 32,
    parameter int SHIFT      = 0,
    parameter int SATURATE   = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] a_dout,
    input  logic                  a_empty,
    output logic                  a_rd_en,
    input  logic [DATA_WIDTH-1:0] b_dout,
    input  logic                  b_empty,
    output logic                  b_rd_en,
    input  logic [1:0]            op_sel,
    output logic [DATA_WIDTH-1:0] out_din,
    input  logic                  out_full,
    output logic                  out_wr_en,
    output logic [CNT_WIDTH-1:0]  sample_count
);

    // Two guard bits: one for the add/sub carry, one so the rounding bias
    // (up to 2^DATA_WIDTH-1 for the halving op) never overflows.
    localparam int EW = DATA_WIDTH + 2;
    localparam logic [EW-1:0]        ONE    = EW'(1);
    localparam logic signed [EW-1:0] BIAS_N = signed'((ONE << SHIFT) - ONE);
    localparam logic signed [EW-1:0] BIAS_H = signed'((ONE << (SHIFT + 1)) - ONE);
    localparam logic signed [EW-1:0] MAX_V  = {3'b000, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] MIN_V  = {3'b111, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [DATA_WIDTH-1:0] r_hold_data;
    logic [CNT_WIDTH-1:0]  r_sample_count;

    logic                  w_hold_valid;
    logic                  w_pop;
    logic                  w_wr;
    logic                  w_half;
    logic signed [EW-1:0]  w_a;
    logic signed [EW-1:0]  w_b;
    logic signed [EW-1:0]  w_sum;
    logic signed [EW-1:0]  w_rounded;
    logic signed [EW-1:0]  w_shifted;
    logic [DATA_WIDTH-1:0] w_result;

    assign w_hold_valid = (r_state == S_FULL);
    assign w_wr         = w_hold_valid & ~out_full;
    // Gated by reset so no FIFO is popped while the block is held in reset.
    assign w_pop        = ~reset & ~a_empty & ~b_empty & (~w_hold_valid | ~out_full);

    assign a_rd_en      = w_pop;
    assign b_rd_en      = w_pop;
    assign out_wr_en    = w_wr;
    assign out_din      = w_hold_valid ? r_hold_data : '0;
    assign sample_count = r_sample_count;

    // Datapath: sign-extend, combine, round toward zero, shift, clamp.
    always_comb begin
        w_a    = {{2{a_dout[DATA_WIDTH-1]}}, a_dout};
        w_b    = {{2{b_dout[DATA_WIDTH-1]}}, b_dout};
        w_half = (op_sel == 2'b10);
        case (op_sel)
            2'b00:   w_sum = w_a - w_b;
            2'b01:   w_sum = w_a + w_b;
            2'b10:   w_sum = w_a + w_b;
            default: w_sum = w_b - w_a;
        endcase
        w_rounded = w_sum;
        if (w_sum[EW-1]) begin
            w_rounded = w_sum + (w_half ? BIAS_H : BIAS_N);
        end
        w_shifted = w_half ? (w_rounded >>> (SHIFT + 1)) : (w_rounded >>> SHIFT);
        w_result  = w_shifted[DATA_WIDTH-1:0];
        if (SATURATE != 0) begin
            if (w_shifted > MAX_V) begin
                w_result = MAX_V[DATA_WIDTH-1:0];
            end else if (w_shifted < MIN_V) begin
                w_result = MIN_V[DATA_WIDTH-1:0];
            end
        end
    end

    // Output register occupancy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_EMPTY: begin
                if (w_pop) begin
                    w_next_state = S_FULL;
                end
            end
            S_FULL: begin
                if (w_pop) begin
                    w_next_state = S_FULL;
                end else if (w_wr) begin
                    w_next_state = S_EMPTY;
                end
            end
            default: w_next_state = S_EMPTY;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hold_data    <= '0;
            r_sample_count <= '0;
        end else begin
            if (w_pop) begin
                r_hold_data <= w_result;
            end
            if (w_wr) begin
                r_sample_count <= r_sample_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_channel_combiner.sv
// tb_channel_combiner
//   Four instances share one set of FIFO-side inputs: default parameters,
//   SATURATE=0, SHIFT=10 and CNT_WIDTH=3. The bench models the two input
//   FIFOs as one queue of vectors; each vector carries its expected result
//   for every parameter set and moves to the scoreboard when it is popped.
module tb_channel_combiner;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] a_dout;
    logic        a_empty;
    logic [31:0] b_dout;
    logic        b_empty;
    logic [1:0]  op_sel;
    logic        out_full;

    logic        a_rd_en, b_rd_en, out_wr_en;
    logic [31:0] out_din;
    logic [15:0] sample_count;
    logic        t_a_rd_en, t_b_rd_en, t_wr_en;
    logic [31:0] t_din;
    logic [15:0] t_cnt;
    logic        s_a_rd_en, s_b_rd_en, s_wr_en;
    logic [31:0] s_din;
    logic [15:0] s_cnt;
    logic        c_a_rd_en, c_b_rd_en, c_wr_en;
    logic [31:0] c_din;
    logic [2:0]  c_cnt;

    always #5 clock = ~clock;

    channel_combiner #(.DATA_WIDTH(32), .SHIFT(0), .SATURATE(1), .CNT_WIDTH(16)) u_dut (
        .clock(clock), .reset(reset),
        .a_dout(a_dout), .a_empty(a_empty), .a_rd_en(a_rd_en),
        .b_dout(b_dout), .b_empty(b_empty), .b_rd_en(b_rd_en),
        .op_sel(op_sel), .out_din(out_din), .out_full(out_full),
        .out_wr_en(out_wr_en), .sample_count(sample_count)
    );

    channel_combiner #(.DATA_WIDTH(32), .SHIFT(0), .SATURATE(0), .CNT_WIDTH(16)) u_trunc (
        .clock(clock), .reset(reset),
        .a_dout(a_dout), .a_empty(a_empty), .a_rd_en(t_a_rd_en),
        .b_dout(b_dout), .b_empty(b_empty), .b_rd_en(t_b_rd_en),
        .op_sel(op_sel), .out_din(t_din), .out_full(out_full),
        .out_wr_en(t_wr_en), .sample_count(t_cnt)
    );

    channel_combiner #(.DATA_WIDTH(32), .SHIFT(10), .SATURATE(1), .CNT_WIDTH(16)) u_sh10 (
        .clock(clock), .reset(reset),
        .a_dout(a_dout), .a_empty(a_empty), .a_rd_en(s_a_rd_en),
        .b_dout(b_dout), .b_empty(b_empty), .b_rd_en(s_b_rd_en),
        .op_sel(op_sel), .out_din(s_din), .out_full(out_full),
        .out_wr_en(s_wr_en), .sample_count(s_cnt)
    );

    channel_combiner #(.DATA_WIDTH(32), .SHIFT(0), .SATURATE(1), .CNT_WIDTH(3)) u_cnt3 (
        .clock(clock), .reset(reset),
        .a_dout(a_dout), .a_empty(a_empty), .a_rd_en(c_a_rd_en),
        .b_dout(b_dout), .b_empty(b_empty), .b_rd_en(c_b_rd_en),
        .op_sel(op_sel), .out_din(c_din), .out_full(out_full),
        .out_wr_en(c_wr_en), .sample_count(c_cnt)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] em;   // SHIFT=0, SATURATE=1
        logic [31:0] et;   // SHIFT=0, SATURATE=0
        logic [31:0] es;   // SHIFT=10, SATURATE=1
    } vec_t;

    vec_t        in_q[$];
    vec_t        sb[$];
    vec_t        tbl[11];
    int          checks = 0;
    int          errors = 0;
    int unsigned exp_cnt = 0;
    bit          did_pop = 1'b0;
    bit          hold_a = 1'b0;
    bit          hold_b = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: divide toward zero by 2^sh, then clamp or wrap.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op, input int sh0, input bit sat);
        longint sa, sbv, x;
        int     sh;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        case (op)
            2'b00:   x = sa - sbv;
            2'b01:   x = sa + sbv;
            2'b10:   x = sa + sbv;
            default: x = sbv - sa;
        endcase
        sh = sh0 + ((op == 2'b10) ? 1 : 0);
        if (x < 0) x = x + ((longint'(1) << sh) - 1);
        x = x >>> sh;
        if (sat) begin
            if (x > 64'sd2147483647) x = 64'sd2147483647;
            if (x < -64'sd2147483648) x = -64'sd2147483648;
        end
        return x[31:0];
    endfunction

    task automatic enq(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        vec_t v;
        v.a  = a;
        v.b  = b;
        v.op = op;
        v.em = model(a, b, op, 0, 1'b1);
        v.et = model(a, b, op, 0, 1'b0);
        v.es = model(a, b, op, 10, 1'b1);
        in_q.push_back(v);
    endtask

    task automatic apply();
        a_empty = (in_q.size() == 0) || hold_a;
        b_empty = (in_q.size() == 0) || hold_b;
        if (in_q.size() != 0) begin
            a_dout = in_q[0].a;
            b_dout = in_q[0].b;
            op_sel = in_q[0].op;
        end else begin
            a_dout = '0;
            b_dout = '0;
            op_sel = 2'b00;
        end
    endtask

    task automatic monitor();
        bit          exp_pop, exp_wr;
        logic [31:0] em, et, es;
        exp_pop = !a_empty && !b_empty && (sb.size() == 0 || !out_full);
        exp_wr  = (sb.size() != 0) && !out_full;
        em = (sb.size() != 0) ? sb[0].em : 32'h0;
        et = (sb.size() != 0) ? sb[0].et : 32'h0;
        es = (sb.size() != 0) ? sb[0].es : 32'h0;
        chk("a_rd_en", 32'(a_rd_en), 32'(exp_pop));
        chk("b_rd_en", 32'(b_rd_en), 32'(exp_pop));
        chk("out_wr_en", 32'(out_wr_en), 32'(exp_wr));
        chk("out_din", out_din, em);
        chk("sample_count", 32'(sample_count), 32'(exp_cnt[15:0]));
        chk("trunc_rd_en", 32'({t_a_rd_en, t_b_rd_en}), 32'({exp_pop, exp_pop}));
        chk("trunc_wr_en", 32'(t_wr_en), 32'(exp_wr));
        chk("trunc_din", t_din, et);
        chk("trunc_count", 32'(t_cnt), 32'(exp_cnt[15:0]));
        chk("sh10_rd_en", 32'({s_a_rd_en, s_b_rd_en}), 32'({exp_pop, exp_pop}));
        chk("sh10_wr_en", 32'(s_wr_en), 32'(exp_wr));
        chk("sh10_din", s_din, es);
        chk("sh10_count", 32'(s_cnt), 32'(exp_cnt[15:0]));
        chk("cnt3_rd_en", 32'({c_a_rd_en, c_b_rd_en}), 32'({exp_pop, exp_pop}));
        chk("cnt3_wr_en", 32'(c_wr_en), 32'(exp_wr));
        chk("cnt3_din", c_din, em);
        chk("cnt3_count", 32'(c_cnt), 32'(exp_cnt[2:0]));
        if (exp_wr) begin
            void'(sb.pop_front());
            exp_cnt++;
        end
        if (exp_pop) sb.push_back(in_q[0]);
        did_pop = exp_pop;
    endtask

    task automatic cycle();
        apply();
        @(negedge clock);
        monitor();
        @(posedge clock);
        #1;
        if (did_pop) void'(in_q.pop_front());
    endtask

    task automatic drain(input string name, input int budget, output int n);
        n = 0;
        while ((in_q.size() != 0 || sb.size() != 0) && n < budget) begin
            cycle();
            n++;
        end
        chk({name, "_drained"}, 32'(in_q.size() + sb.size()), 32'h0);
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_rd_en"}, 32'({a_rd_en, b_rd_en}), 32'h0);
        chk({name, "_wr_en"}, 32'(out_wr_en), 32'h0);
        chk({name, "_din"}, out_din, 32'h0);
        chk({name, "_count"}, 32'(sample_count), 32'h0);
        chk({name, "_sh10_count"}, 32'(s_cnt), 32'h0);
    endtask

    initial begin
        int n;
        int unsigned start;

        reset    = 1'b1;
        out_full = 1'b0;
        apply();
        #3;
        chk_reset("reset");
        @(posedge clock);
        #1;
        reset = 1'b0;

        // a, b, op, sat, trunc, shift10
        tbl[0]  = '{32'd100,      32'd30,       2'b00, 32'd70,       32'd70,       32'd0};
        tbl[1]  = '{32'h7FFFFFFF, 32'd1,        2'b01, 32'h7FFFFFFF, 32'h80000000, 32'h00200000};
        tbl[2]  = '{32'h80000000, 32'd1,        2'b00, 32'h80000000, 32'h7FFFFFFF, 32'hFFE00000};
        tbl[3]  = '{32'hFFFFFBFF, 32'd0,        2'b00, 32'hFFFFFBFF, 32'hFFFFFBFF, 32'hFFFFFFFF};
        tbl[4]  = '{32'hFFFFFFFD, 32'd0,        2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
        tbl[5]  = '{32'd5,        32'd12,       2'b11, 32'd7,        32'd7,        32'd0};
        tbl[6]  = '{32'd7,        32'd4,        2'b10, 32'd5,        32'd5,        32'd0};
        tbl[7]  = '{32'h80000000, 32'h80000000, 2'b10, 32'h80000000, 32'h80000000, 32'hFFE00000};
        tbl[8]  = '{32'h7FFFFFFF, 32'h80000000, 2'b11, 32'h80000000, 32'h00000001, 32'hFFC00001};
        tbl[9]  = '{32'd5120,     32'd0,        2'b01, 32'd5120,     32'd5120,     32'd5};
        tbl[10] = '{32'hFFFFF800, 32'd0,        2'b01, 32'hFFFFF800, 32'hFFFFF800, 32'hFFFFFFFE};

        // First vector alone: pop, then write one cycle later, count = 1.
        in_q.push_back(tbl[0]);
        drain("first", 20, n);
        chk("first_latency_cycles", 32'(n), 32'd2);
        chk("first_count", 32'(sample_count), 32'd1);

        for (int i = 1; i < 11; i++) in_q.push_back(tbl[i]);
        drain("table", 60, n);

        // Back-to-back stream: 8 pops and 8 writes in 9 cycles.
        start = exp_cnt;
        for (int i = 1; i <= 8; i++) enq(32'(i), 32'd0, 2'b01);
        drain("stream", 40, n);
        chk("stream_cycles", 32'(n), 32'd9);
        chk("stream_count", 32'(sample_count), 32'((start + 8) & 32'hFFFF));

        // Backpressure: one word held, nothing else popped, data stable.
        out_full = 1'b1;
        enq(32'd40, 32'd2, 2'b00);
        for (int i = 0; i < 4; i++) enq(32'(i + 1000), 32'd3, 2'(i));
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_held_din", out_din, 32'd38);
        end
        out_full = 1'b0;
        drain("bp_release", 40, n);

        // Reset while a word is held and the output is full.
        out_full = 1'b1;
        enq(32'd500, 32'd1, 2'b01);
        enq(32'd9, 32'd9, 2'b01);
        cycle();
        cycle();
        chk("pre_reset_din", out_din, 32'd501);
        reset = 1'b1;
        #1;
        chk_reset("rst_mid");
        out_full = 1'b0;
        #1;
        chk_reset("rst_release_full");
        sb.delete();
        exp_cnt = 0;
        @(negedge clock);
        chk_reset("rst_hold");
        @(posedge clock);
        #1;
        reset = 1'b0;
        drain("after_reset", 20, n);
        chk("after_reset_din_count", 32'(sample_count), 32'd1);

        // Only A has data: never pop either side.
        hold_b = 1'b1;
        enq(32'd3, 32'd4, 2'b01);
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("one_sided_rd", 32'({a_rd_en, b_rd_en}), 32'h0);
        end
        hold_b = 1'b0;
        drain("one_sided_release", 20, n);

        // Random traffic with random backpressure and one-sided starvation.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) != 0 && in_q.size() < 4) begin
                case ($urandom_range(0, 3))
                    0:       enq(32'h80000000, $urandom(), 2'($urandom_range(0, 3)));
                    1:       enq(32'h7FFFFFFF, $urandom(), 2'($urandom_range(0, 3)));
                    default: enq($urandom(), $urandom(), 2'($urandom_range(0, 3)));
                endcase
            end
            out_full = ($urandom_range(0, 3) == 0);
            hold_a   = ($urandom_range(0, 7) == 0);
            hold_b   = ($urandom_range(0, 7) == 0);
            cycle();
        end
        out_full = 1'b0;
        hold_a   = 1'b0;
        hold_b   = 1'b0;
        drain("random", 60, n);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
